// File: rtl/xm_wb_pkg.sv
// Shared write-back types: source selector, sequencer states and the PC register index.
package xm_wb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    ALU  = 2'b01,
    MEM  = 2'b10,
    PC   = 2'b11
  } wb_src_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    WRITE    = 2'b10,
    FINISH   = 2'b11
  } wb_state_t;

  localparam int PC_REG = 7;

endpackage

// File: rtl/wb_sequencer.sv
// Write-back sequencer: reg_we at start+1 (ALU/PC) or one cycle after mem_ready (MEM), done one cycle later.
// No backpressure; start is ignored while busy, and a MEM wait aborts with wb_error after MEM_TIMEOUT cycles.
module wb_sequencer
  import xm_wb_pkg::*;
#(
  parameter int REG_ADDR_W  = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            wb_src,
  input  logic [REG_ADDR_W-1:0] dst_reg,
  input  logic                  mem_ready,
  output logic                  mem_wr,
  output logic                  pc_wr,
  output logic                  reg_we,
  output logic [REG_ADDR_W-1:0] reg_addr,
  output logic                  pc_dst,
  output logic                  busy,
  output logic                  done,
  output logic                  wb_error
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  wb_state_t             state_q, state_d;
  wb_src_t               src_q, src_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  mem_wr_q, mem_wr_d;
  logic                  pc_wr_q, pc_wr_d;
  logic                  reg_we_q, reg_we_d;
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic                  pc_dst_q, pc_dst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wb_error_q, wb_error_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= NONE;
      dst_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = wb_src_t'(wb_src);
          dst_d = dst_reg;
          cnt_d = '0;
          case (wb_src_t'(wb_src))
            NONE:    state_d = FINISH;
            MEM:     state_d = WAIT_MEM;
            default: state_d = WRITE;
          endcase
        end
      end
      WAIT_MEM: begin
        // mem_ready wins over a timeout landing in the same cycle
        if (mem_ready) begin
          state_d = WRITE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      WRITE:   state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    mem_wr_d   = (src_d == MEM) && ((state_d == WAIT_MEM) || (state_d == WRITE));
    pc_wr_d    = (src_d == PC) && ((state_d == WAIT_MEM) || (state_d == WRITE));
    reg_we_d   = (state_d == WRITE);
    reg_addr_d = reg_we_d ? dst_d : '0;
    pc_dst_d   = reg_we_d && (dst_d == PC_ADDR);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == FINISH);
    wb_error_d = (state_q == WAIT_MEM) && !mem_ready && (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wr_q   <= 1'b0;
      pc_wr_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      reg_addr_q <= '0;
      pc_dst_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wb_error_q <= 1'b0;
    end else begin
      mem_wr_q   <= mem_wr_d;
      pc_wr_q    <= pc_wr_d;
      reg_we_q   <= reg_we_d;
      reg_addr_q <= reg_addr_d;
      pc_dst_q   <= pc_dst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wb_error_q <= wb_error_d;
    end
  end

  assign mem_wr   = mem_wr_q;
  assign pc_wr    = pc_wr_q;
  assign reg_we   = reg_we_q;
  assign reg_addr = reg_addr_q;
  assign pc_dst   = pc_dst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wb_error = wb_error_q;

endmodule
